// File: rtl/data_table_arbiter_pkg.sv
// Shared types and constants for the data-table arbiter.
// Engine indices and RAM word layout.
package data_table_arbiter_pkg;

  localparam int ENGINES_CNT      = 3;
  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int RAM_LATENCY      = 2;

  typedef logic [$clog2(ENGINES_CNT)-1:0] ht_engine_idx_t;

  localparam ht_engine_idx_t SEARCH_ENG = 0;
  localparam ht_engine_idx_t INSERT_ENG = 1;
  localparam ht_engine_idx_t DELETE_ENG = 2;

  typedef struct packed {
    logic [15:0] key;
    logic [15:0] value;
  } ram_data_t;

endpackage

// File: rtl/data_table_arbiter_if.sv
// Engine-side bus of the data-table arbiter.
// master = engines, slave = arbiter.
interface data_table_arbiter_if
  import data_table_arbiter_pkg::*;
#(
  parameter int N  = ENGINES_CNT,
  parameter int AW = TABLE_ADDR_WIDTH,
  parameter int DW = $bits(ram_data_t)
);

  logic [N-1:0]    req_i;
  logic [N-1:0]    release_i;
  logic [N-1:0]    grant_o;
  logic [N-1:0]    eng_rd_en_i;
  logic [N*AW-1:0] eng_rd_addr_i;
  logic [N-1:0]    eng_wr_en_i;
  logic [N*AW-1:0] eng_wr_addr_i;
  logic [N*DW-1:0] eng_wr_data_i;
  logic [DW-1:0]   eng_rd_data_o;
  logic [N-1:0]    eng_rd_data_val_o;

  modport master (
    output req_i,
    output release_i,
    input  grant_o,
    output eng_rd_en_i,
    output eng_rd_addr_i,
    output eng_wr_en_i,
    output eng_wr_addr_i,
    output eng_wr_data_i,
    input  eng_rd_data_o,
    input  eng_rd_data_val_o
  );

  modport slave (
    input  req_i,
    input  release_i,
    output grant_o,
    input  eng_rd_en_i,
    input  eng_rd_addr_i,
    input  eng_wr_en_i,
    input  eng_wr_addr_i,
    input  eng_wr_data_i,
    output eng_rd_data_o,
    output eng_rd_data_val_o
  );

endinterface

// File: rtl/data_table_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
// Searches from the index after last_i, wrapping.
module data_table_arbiter_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // first requester after last_i wins
  always_comb begin
    int c;
    c      = 0;
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last_i) + i) % N;
      if (!any_o && req_i[c]) begin
        any_o     = 1'b1;
        pick_o[c] = 1'b1;
        idx_o     = IW'(c);
      end
    end
  end

endmodule

// File: rtl/data_table_arbiter.sv
// Data-table RAM arbiter: task-long ownership,
// round-robin grants, tagged read-valid routing.
module data_table_arbiter
  import data_table_arbiter_pkg::*;
#(
  parameter int ENGINES_CNT = data_table_arbiter_pkg::ENGINES_CNT,
  parameter int A_WIDTH     = TABLE_ADDR_WIDTH,
  parameter int D_WIDTH     = $bits(ram_data_t),
  parameter int RAM_LATENCY = data_table_arbiter_pkg::RAM_LATENCY
) (
  input  logic               clk_i,
  input  logic               rst_i,
  data_table_arbiter_if.slave eng,
  output logic               ram_rd_en_o,
  output logic [A_WIDTH-1:0] ram_rd_addr_o,
  output logic               ram_wr_en_o,
  output logic [A_WIDTH-1:0] ram_wr_addr_o,
  output logic [D_WIDTH-1:0] ram_wr_data_o,
  input  logic [D_WIDTH-1:0] ram_rd_data_i,
  output logic               err_o
);

  localparam int IW = (ENGINES_CNT > 1) ? $clog2(ENGINES_CNT) : 1;
  localparam int CW = $clog2(RAM_LATENCY + 1);

  localparam logic [1:0] IDLE_S  = 2'd0;
  localparam logic [1:0] GRANT_S = 2'd1;
  localparam logic [1:0] DRAIN_S = 2'd2;

  logic [1:0]             state_q;
  logic [ENGINES_CNT-1:0] grant_q;
  logic [IW-1:0]          owner_q;
  logic [IW-1:0]          rr_last_q;
  logic                   err_q;
  logic [RAM_LATENCY-1:0] pipe_val_q;
  logic [IW-1:0]          pipe_idx_q [RAM_LATENCY];
  logic [CW-1:0]          inflight_q;
  logic [CW-1:0]          inflight_d;

  logic [ENGINES_CNT-1:0] pick;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;
  logic                   owned;
  logic                   rd_issue;
  logic                   rd_ret;
  logic                   release_own;
  logic                   stray;
  logic [ENGINES_CNT-1:0] val_vec;

  data_table_arbiter_rr_arbiter #(
    .N  (ENGINES_CNT),
    .IW (IW)
  ) u_rr (
    .req_i  (eng.req_i),
    .last_i (rr_last_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign owned       = (state_q == GRANT_S);
  assign rd_issue    = owned & eng.eng_rd_en_i[owner_q];
  assign release_own = owned & eng.release_i[owner_q];
  assign rd_ret      = pipe_val_q[RAM_LATENCY-1];
  assign stray       = |((eng.eng_rd_en_i | eng.eng_wr_en_i) & ~grant_q);
  assign inflight_d  = inflight_q + CW'(rd_issue) - CW'(rd_ret);

  assign ram_rd_en_o   = rd_issue;
  assign ram_rd_addr_o = eng.eng_rd_addr_i[owner_q*A_WIDTH +: A_WIDTH];
  assign ram_wr_en_o   = owned & eng.eng_wr_en_i[owner_q];
  assign ram_wr_addr_o = eng.eng_wr_addr_i[owner_q*A_WIDTH +: A_WIDTH];
  assign ram_wr_data_o = eng.eng_wr_data_i[owner_q*D_WIDTH +: D_WIDTH];

  assign eng.grant_o           = grant_q;
  assign eng.eng_rd_data_o     = ram_rd_data_i;
  assign eng.eng_rd_data_val_o = val_vec;
  assign err_o                 = err_q;

  // route the returning valid to the engine tagged at issue
  always_comb begin
    val_vec = '0;
    val_vec[pipe_idx_q[RAM_LATENCY-1]] = rd_ret;
  end

  // ownership FSM; grants only leave IDLE_S
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE_S;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_last_q <= IW'(ENGINES_CNT - 1);
    end else begin
      unique case (state_q)
        IDLE_S: begin
          if (pick_any) begin
            grant_q   <= pick;
            owner_q   <= pick_idx;
            rr_last_q <= pick_idx;
            state_q   <= GRANT_S;
          end
        end
        GRANT_S: begin
          if (release_own) begin
            grant_q <= '0;
            state_q <= (inflight_d != '0) ? DRAIN_S : IDLE_S;
          end
        end
        DRAIN_S: begin
          if (inflight_d == '0) state_q <= IDLE_S;
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  // read tag pipeline and in-flight count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_val_q <= '0;
      inflight_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) pipe_idx_q[i] <= '0;
    end else begin
      pipe_val_q[0] <= rd_issue;
      pipe_idx_q[0] <= owner_q;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_val_q[i] <= pipe_val_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
      inflight_q <= inflight_d;
    end
  end

  // sticky flag for any access by a non-owner
  always_ff @(posedge clk_i) begin
    if (rst_i)      err_q <= 1'b0;
    else if (stray) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_data_table_arbiter.sv
// Directed bench for data_table_arbiter.
// 2-cycle RAM model returns {24'hABCDEF, addr}.
module tb_data_table_arbiter;
  import data_table_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        ram_rd_en;
  logic [7:0]  ram_rd_addr;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic [31:0] ram_rd_data;
  logic        err;
  logic [31:0] rq0;
  logic [31:0] rq1;
  int          checks;
  int          errors;
  int          order [4];

  data_table_arbiter_if bus ();

  data_table_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .eng           (bus),
    .ram_rd_en_o   (ram_rd_en),
    .ram_rd_addr_o (ram_rd_addr),
    .ram_wr_en_o   (ram_wr_en),
    .ram_wr_addr_o (ram_wr_addr),
    .ram_wr_data_o (ram_wr_data),
    .ram_rd_data_i (ram_rd_data),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rq0 <= {24'hABCDEF, ram_rd_addr};
    rq1 <= rq0;
  end
  assign ram_rd_data = rq1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    order[0] = int'(SEARCH_ENG);
    order[1] = int'(INSERT_ENG);
    order[2] = int'(DELETE_ENG);
    order[3] = int'(SEARCH_ENG);
    rst = 1'b1;
    bus.req_i = '0;
    bus.release_i = '0;
    bus.eng_rd_en_i = '0;
    bus.eng_rd_addr_i = '0;
    bus.eng_wr_en_i = '0;
    bus.eng_wr_addr_i = '0;
    bus.eng_wr_data_i = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_grant", bus.grant_o, 3'b000);
    chk("rst_err", err, 1'b0);
    chk("rst_val", bus.eng_rd_data_val_o, 3'b000);
    chk("rst_rd_en", ram_rd_en, 1'b0);

    // 1: single grant, read routed to eng0 at +2
    bus.req_i = 3'b001;
    tick();
    chk("t1_grant", bus.grant_o, 3'b001);
    bus.eng_rd_en_i = 3'b001;
    bus.eng_rd_addr_i[7:0] = 8'd5;
    #1;
    chk("t1_rd_en", ram_rd_en, 1'b1);
    chk("t1_rd_addr", ram_rd_addr, 8'd5);
    tick();
    bus.eng_rd_en_i = '0;
    #1;
    chk("t1_val_p1", bus.eng_rd_data_val_o, 3'b000);
    tick();
    chk("t1_val_p2", bus.eng_rd_data_val_o, 3'b001);
    chk("t1_data", bus.eng_rd_data_o, 32'hABCDEF05);
    bus.req_i = '0;
    bus.release_i = 3'b001;
    tick();
    bus.release_i = '0;
    chk("t1_released", bus.grant_o, 3'b000);

    // 2: all requesting, rotation 0,1,2,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_i = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant", bus.grant_o, 3'b001 << order[k]);
      bus.eng_rd_en_i = 3'b001 << order[k];
      bus.eng_rd_addr_i[order[k]*8 +: 8] = 8'(16 + order[k]);
      tick();
      bus.eng_rd_en_i = '0;
      bus.release_i = 3'b001 << order[k];
      tick();
      chk("t2_rel_grant", bus.grant_o, 3'b000);
      chk("t2_val", bus.eng_rd_data_val_o, 3'b001 << order[k]);
      chk("t2_data", bus.eng_rd_data_o, {24'hABCDEF, 8'(16 + order[k])});
      bus.release_i = '0;
      tick();
      chk("t2_val_off", bus.eng_rd_data_val_o, 3'b000);
      chk("t2_gap", bus.grant_o, 3'b000);
      tick();
    end
    chk("t2_next", bus.grant_o, 3'b010);
    bus.req_i = '0;

    // 3: read with release drains before next grant
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_i = 3'b011;
    tick();
    chk("t3_grant0", bus.grant_o, 3'b001);
    bus.eng_rd_en_i = 3'b001;
    bus.eng_rd_addr_i[7:0] = 8'd7;
    bus.release_i = 3'b001;
    #1;
    chk("t3_fwd", ram_rd_en, 1'b1);
    tick();
    bus.eng_rd_en_i = '0;
    bus.release_i = '0;
    bus.req_i = 3'b010;
    chk("t3_drain1_g", bus.grant_o, 3'b000);
    chk("t3_drain1_v", bus.eng_rd_data_val_o, 3'b000);
    tick();
    chk("t3_drain2_v", bus.eng_rd_data_val_o, 3'b001);
    chk("t3_drain2_g", bus.grant_o, 3'b000);
    tick();
    chk("t3_idle_g", bus.grant_o, 3'b000);
    tick();
    chk("t3_grant1", bus.grant_o, 3'b010);
    bus.req_i = '0;

    // 4: non-owner write masked, err sticky
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_i = 3'b001;
    tick();
    chk("t4_grant", bus.grant_o, 3'b001);
    bus.eng_wr_en_i = 3'b100;
    bus.eng_wr_addr_i[23:16] = 8'd9;
    #1;
    chk("t4_masked", ram_wr_en, 1'b0);
    tick();
    bus.eng_wr_en_i = '0;
    chk("t4_err", err, 1'b1);
    tick();
    chk("t4_sticky", err, 1'b1);
    bus.eng_wr_en_i = 3'b001;
    bus.eng_wr_addr_i[7:0] = 8'd3;
    bus.eng_wr_data_i[31:0] = 32'h12345678;
    #1;
    chk("t4_own_wr", ram_wr_en, 1'b1);
    chk("t4_wr_addr", ram_wr_addr, 8'd3);
    chk("t4_wr_data", ram_wr_data, 32'h12345678);
    tick();
    bus.eng_wr_en_i = '0;
    bus.req_i = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_err_clr", err, 1'b0);

    // 5: reset with a read in flight
    bus.req_i = 3'b001;
    tick();
    chk("t5_grant", bus.grant_o, 3'b001);
    bus.eng_rd_en_i = 3'b001;
    bus.eng_rd_addr_i[7:0] = 8'd4;
    tick();
    bus.eng_rd_en_i = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_i = 3'b111;
    chk("t5_grant_lost", bus.grant_o, 3'b000);
    chk("t5_val", bus.eng_rd_data_val_o, 3'b000);
    chk("t5_err", err, 1'b0);
    tick();
    chk("t5_val_flushed", bus.eng_rd_data_val_o, 3'b000);
    chk("t5_eng0_first", bus.grant_o, 3'b001);
    bus.req_i = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
